// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings and decode helpers for the M-extension multiply/divide controller.
package muldiv_ctrl_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic UNIT_MUL = 1'b0;
  localparam logic UNIT_DIV = 1'b1;

  localparam logic OPND_SIGNED   = 1'b0;
  localparam logic OPND_UNSIGNED = 1'b1;

  function automatic logic is_div(input logic [2:0] op);
    is_div = (op >= OP_DIV);
  endfunction

  function automatic logic a_unsigned(input logic [2:0] op);
    case (op)
      OP_MULH, OP_MULHSU, OP_DIV, OP_REM: a_unsigned = OPND_SIGNED;
      default:                            a_unsigned = OPND_UNSIGNED;
    endcase
  endfunction

  function automatic logic b_unsigned(input logic [2:0] op);
    case (op)
      OP_MULH, OP_DIV, OP_REM: b_unsigned = OPND_SIGNED;
      default:                 b_unsigned = OPND_UNSIGNED;
    endcase
  endfunction

  // Low word for MUL and remainders, high word for upper products and quotients.
  function automatic logic [DATA_W-1:0] select_result(input logic [2:0] op,
                                                      input logic [2*DATA_W-1:0] r);
    case (op)
      OP_MUL, OP_REM, OP_REMU: select_result = r[DATA_W-1:0];
      default:                 select_result = r[2*DATA_W-1:DATA_W];
    endcase
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Pipeline-side request/result signals and iterative-unit handshake of the muldiv controller.
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;

  logic              req_valid_i;
  logic [2:0]        op_i;
  logic [DATA_W-1:0] rs1_i;
  logic [DATA_W-1:0] rs2_i;
  logic              flush_i;
  logic              stall_o;
  logic [DATA_W-1:0] result_o;
  logic              result_valid_o;

  logic                unit_start_o;
  logic                unit_mul_or_div_o;
  logic [DATA_W-1:0]   unit_op_a_o;
  logic [DATA_W-1:0]   unit_op_b_o;
  logic                unit_a_unsigned_o;
  logic                unit_b_unsigned_o;
  logic                unit_cancel_o;
  logic [2*DATA_W-1:0] unit_result_i;
  logic                unit_done_i;

  modport master (
    output req_valid_i, op_i, rs1_i, rs2_i, flush_i, unit_result_i, unit_done_i,
    input  stall_o, result_o, result_valid_o, unit_start_o, unit_mul_or_div_o,
           unit_op_a_o, unit_op_b_o, unit_a_unsigned_o, unit_b_unsigned_o, unit_cancel_o
  );

  modport slave (
    input  req_valid_i, op_i, rs1_i, rs2_i, flush_i, unit_result_i, unit_done_i,
    output stall_o, result_o, result_valid_o, unit_start_o, unit_mul_or_div_o,
           unit_op_a_o, unit_op_b_o, unit_a_unsigned_o, unit_b_unsigned_o, unit_cancel_o
  );
endinterface

// File: rtl/muldiv_special.sv
// Combinational detection of divide-by-zero and signed overflow with their fixed {quotient, remainder}.
module muldiv_special
  import muldiv_ctrl_pkg::*;
(
  input  logic [2:0]          op,
  input  logic [DATA_W-1:0]   rs1,
  input  logic [DATA_W-1:0]   rs2,
  output logic                special,
  output logic [2*DATA_W-1:0] result
);

  logic div_zero;
  logic div_ovf;

  assign div_zero = is_div(op) && (rs2 == '0);
  // Only the signed forms can overflow: most negative divided by minus one.
  assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                    (rs1 == {1'b1, {(DATA_W-1){1'b0}}}) && (rs2 == '1);

  assign special = div_zero || div_ovf;
  assign result  = div_zero ? {{DATA_W{1'b1}}, rs1}
                            : {1'b1, {(DATA_W-1){1'b0}}, {DATA_W{1'b0}}};

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage controller sequencing an iterative multiply/divide unit.
// Optional result cache for repeated DIV-class operands: define MULDIV_CACHE_EN.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  muldiv_ctrl_if.slave bus
);

  logic [1:0]        state;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;
  logic              a_uns_q;
  logic              b_uns_q;
  logic              mul_or_div_q;
  logic              start_q;

  logic                accept;
  logic                sp_hit;
  logic [2*DATA_W-1:0] sp_res;
  logic                cache_hit;
  logic [2*DATA_W-1:0] cache_res;
  logic                fast;
  logic [2*DATA_W-1:0] fast_res;

  muldiv_special u_special (
    .op      (bus.op_i),
    .rs1     (bus.rs1_i),
    .rs2     (bus.rs2_i),
    .special (sp_hit),
    .result  (sp_res)
  );

  assign accept = (state == S_IDLE) && bus.req_valid_i && !bus.flush_i;

`ifdef MULDIV_CACHE_EN
  logic                c_vld;
  logic [DATA_W-1:0]   c_a;
  logic [DATA_W-1:0]   c_b;
  logic                c_au;
  logic                c_bu;
  logic [2*DATA_W-1:0] c_res;
  logic                c_store;

  assign c_store   = (state == S_BUSY) && !bus.flush_i && bus.unit_done_i && is_div(op_q);
  assign cache_hit = c_vld && is_div(bus.op_i) &&
                     (c_a == bus.rs1_i) && (c_b == bus.rs2_i) &&
                     (c_au == a_unsigned(bus.op_i)) && (c_bu == b_unsigned(bus.op_i));
  assign cache_res = c_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      c_vld <= 1'b0;
    else if (bus.flush_i || (accept && !is_div(bus.op_i)))
      c_vld <= 1'b0;
    else if (c_store)
      c_vld <= 1'b1;
  end

  // Entry payload is only meaningful while c_vld is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (c_store) begin
      c_a   <= op_a_q;
      c_b   <= op_b_q;
      c_au  <= a_uns_q;
      c_bu  <= b_uns_q;
      c_res <= bus.unit_result_i;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

  assign fast     = sp_hit || cache_hit;
  assign fast_res = sp_hit ? sp_res : cache_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      op_q         <= OP_MUL;
      op_a_q       <= '0;
      op_b_q       <= '0;
      a_uns_q      <= OPND_UNSIGNED;
      b_uns_q      <= OPND_UNSIGNED;
      mul_or_div_q <= UNIT_MUL;
      start_q      <= 1'b0;
      result_q     <= '0;
    end else begin
      start_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q         <= bus.op_i;
            op_a_q       <= bus.rs1_i;
            op_b_q       <= bus.rs2_i;
            a_uns_q      <= a_unsigned(bus.op_i);
            b_uns_q      <= b_unsigned(bus.op_i);
            mul_or_div_q <= is_div(bus.op_i) ? UNIT_DIV : UNIT_MUL;
            if (fast) begin
              result_q <= select_result(bus.op_i, fast_res);
              state    <= S_DONE;
            end else begin
              start_q <= 1'b1;
              state   <= S_BUSY;
            end
          end
        end
        // Flush outranks a coincident done; a late done then lands in IDLE and is ignored.
        S_BUSY: begin
          if (bus.flush_i) begin
            state <= S_IDLE;
          end else if (bus.unit_done_i) begin
            result_q <= select_result(op_q, bus.unit_result_i);
            state    <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.stall_o           = bus.req_valid_i && (state != S_DONE);
  assign bus.result_valid_o    = (state == S_DONE) && !bus.flush_i;
  assign bus.result_o          = result_q;
  assign bus.unit_cancel_o     = (state == S_BUSY) && bus.flush_i;
  assign bus.unit_start_o      = start_q;
  assign bus.unit_mul_or_div_o = mul_or_div_q;
  assign bus.unit_op_a_o       = op_a_q;
  assign bus.unit_op_b_o       = op_b_q;
  assign bus.unit_a_unsigned_o = a_uns_q;
  assign bus.unit_b_unsigned_o = b_uns_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl; the unit is modelled by hand-driven done pulses and results.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_bad = 0;
  int   n_start = 0;
  int   s0;

  always #5 clk = ~clk;

  muldiv_ctrl_if bus();

  muldiv_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) if (bus.unit_start_o === 1'b1) n_start++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid_i = 1'b1;
    bus.op_i        = op;
    bus.rs1_i       = a;
    bus.rs2_i       = b;
  endtask

  task automatic run_unit(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [63:0] ures,
                          input logic [31:0] exp, input logic au, input logic bu);
    tick; drive_req(op, a, b);
    smp;  check({tag, "_stall_req"}, 64'(bus.stall_o), 64'd1);
    for (int i = 1; i <= lat; i++) begin
      tick;
      if (i == lat) begin bus.unit_done_i = 1'b1; bus.unit_result_i = ures; end
      smp;
      check({tag, "_stall_busy"}, 64'(bus.stall_o), 64'd1);
      check({tag, "_valid_busy"}, 64'(bus.result_valid_o), 64'd0);
      if (i == 1) begin
        check({tag, "_start"}, 64'(bus.unit_start_o), 64'd1);
        check({tag, "_a_uns"}, 64'(bus.unit_a_unsigned_o), 64'(au));
        check({tag, "_b_uns"}, 64'(bus.unit_b_unsigned_o), 64'(bu));
        check({tag, "_opa"}, 64'(bus.unit_op_a_o), 64'(a));
        check({tag, "_mod"}, 64'(bus.unit_mul_or_div_o), 64'(op[2]));
      end
    end
    tick; bus.unit_done_i = 1'b0; bus.unit_result_i = '0;
    smp;
    check({tag, "_valid"}, 64'(bus.result_valid_o), 64'd1);
    check({tag, "_result"}, 64'(bus.result_o), 64'(exp));
    check({tag, "_stall_done"}, 64'(bus.stall_o), 64'd0);
    tick; bus.req_valid_i = 1'b0;
    smp;
    check({tag, "_valid_after"}, 64'(bus.result_valid_o), 64'd0);
    check({tag, "_hold"}, 64'(bus.result_o), 64'(exp));
  endtask

  task automatic run_fast(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    tick; drive_req(op, a, b);
    smp;  check({tag, "_stall_req"}, 64'(bus.stall_o), 64'd1);
    tick;
    smp;
    check({tag, "_valid"}, 64'(bus.result_valid_o), 64'd1);
    check({tag, "_result"}, 64'(bus.result_o), 64'(exp));
    check({tag, "_stall_done"}, 64'(bus.stall_o), 64'd0);
    check({tag, "_no_start"}, 64'(bus.unit_start_o), 64'd0);
    tick; bus.req_valid_i = 1'b0;
    smp;
    check({tag, "_valid_after"}, 64'(bus.result_valid_o), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid_i   = 1'b0;
    bus.op_i          = '0;
    bus.rs1_i         = '0;
    bus.rs2_i         = '0;
    bus.flush_i       = 1'b0;
    bus.unit_done_i   = 1'b0;
    bus.unit_result_i = '0;
    repeat (2) @(posedge clk);
    smp;
    check("rst_state", 64'(dut.state), 64'(S_IDLE));
    check("rst_stall", 64'(bus.stall_o), 64'd0);
    check("rst_valid", 64'(bus.result_valid_o), 64'd0);
    check("rst_start", 64'(bus.unit_start_o), 64'd0);
    check("rst_cancel", 64'(bus.unit_cancel_o), 64'd0);
    check("rst_result", 64'(bus.result_o), 64'd0);
    check("rst_opa", 64'(bus.unit_op_a_o), 64'd0);
    check("rst_a_uns", 64'(bus.unit_a_unsigned_o), 64'd1);
    check("rst_b_uns", 64'(bus.unit_b_unsigned_o), 64'd1);
    @(posedge clk); #1 rst = 1'b0;

    // MUL 7x6, unit busy three cycles -> valid in cycle 5, exactly one start
    s0 = n_start;
    run_unit("mul", OP_MUL, 32'd7, 32'd6, 3, 64'd42, 32'd42, 1'b1, 1'b1);
    tick;
    check("mul_starts", 64'(n_start - s0), 64'd1);

    s0 = n_start;
    run_fast("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_fast("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    run_fast("remu_z", OP_REMU, 32'd5, 32'd0, 32'd5);
    run_fast("divu_z", OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF);
    run_fast("div_z", OP_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF);
    tick;
    check("special_starts", 64'(n_start - s0), 64'd0);

    run_unit("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 2, 64'hFFFF_FFFF_FFFF_FFFE,
             32'hFFFF_FFFF, 1'b0, 1'b1);
    run_unit("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFE_0000_0001,
             32'hFFFF_FFFE, 1'b1, 1'b1);
    run_unit("mulh", OP_MULH, 32'hFFFF_FFFE, 32'd3, 1, 64'hFFFF_FFFF_FFFF_FFFA,
             32'hFFFF_FFFF, 1'b0, 1'b0);

    // Flush in the second BUSY cycle, stray done two cycles later
    tick; drive_req(OP_DIVU, 32'd100, 32'd7);
    smp;
    tick;
    smp;  check("fl_start", 64'(bus.unit_start_o), 64'd1);
    tick; bus.flush_i = 1'b1; bus.req_valid_i = 1'b0;
    smp;
    check("fl_cancel", 64'(bus.unit_cancel_o), 64'd1);
    check("fl_valid", 64'(bus.result_valid_o), 64'd0);
    tick; bus.flush_i = 1'b0;
    smp;
    check("fl_cancel_off", 64'(bus.unit_cancel_o), 64'd0);
    check("fl_state", 64'(dut.state), 64'(S_IDLE));
    tick; bus.unit_done_i = 1'b1; bus.unit_result_i = {32'd14, 32'd2};
    smp;  check("fl_late_done", 64'(bus.result_valid_o), 64'd0);
    tick; bus.unit_done_i = 1'b0;
    smp;
    check("fl_valid_late", 64'(bus.result_valid_o), 64'd0);
    check("fl_state_late", 64'(dut.state), 64'(S_IDLE));
    check("fl_hold", 64'(bus.result_o), 64'h0000_0000_FFFF_FFFF);

    // Flush coinciding with done
    tick; drive_req(OP_DIV, 32'd100, 32'd7);
    smp;
    tick;
    smp;
    tick; bus.flush_i = 1'b1; bus.unit_done_i = 1'b1; bus.req_valid_i = 1'b0;
    smp;  check("fd_cancel", 64'(bus.unit_cancel_o), 64'd1);
    tick; bus.flush_i = 1'b0; bus.unit_done_i = 1'b0;
    smp;
    check("fd_valid", 64'(bus.result_valid_o), 64'd0);
    check("fd_state", 64'(dut.state), 64'(S_IDLE));
    check("fd_hold", 64'(bus.result_o), 64'h0000_0000_FFFF_FFFF);

    // Flush during DONE
    tick; drive_req(OP_REMU, 32'd5, 32'd0);
    smp;
    tick; bus.flush_i = 1'b1; bus.req_valid_i = 1'b0;
    smp;
    check("fdone_state", 64'(dut.state), 64'(S_DONE));
    check("fdone_valid", 64'(bus.result_valid_o), 64'd0);
    tick; bus.flush_i = 1'b0;
    smp;
    check("fdone_idle", 64'(dut.state), 64'(S_IDLE));
    check("fdone_valid2", 64'(bus.result_valid_o), 64'd0);

    // DIV 100/7 then REM 100/7
    run_unit("div", OP_DIV, 32'd100, 32'd7, 2, {32'd14, 32'd2}, 32'd14, 1'b0, 1'b0);
`ifdef MULDIV_CACHE_EN
    s0 = n_start;
    run_fast("rem_hit", OP_REM, 32'd100, 32'd7, 32'd2);
    run_unit("mul_inv", OP_MUL, 32'd3, 32'd3, 1, 64'd9, 32'd9, 1'b1, 1'b1);
    run_unit("div_miss", OP_DIV, 32'd100, 32'd7, 1, {32'd14, 32'd2}, 32'd14, 1'b0, 1'b0);
    tick;
    check("cache_starts", 64'(n_start - s0), 64'd2);
`else
    s0 = n_start;
    run_unit("rem", OP_REM, 32'd100, 32'd7, 2, {32'd14, 32'd2}, 32'd2, 1'b0, 1'b0);
    tick;
    check("rem_starts", 64'(n_start - s0), 64'd1);
`endif

    // Asynchronous reset while BUSY
    tick; drive_req(OP_MUL, 32'd3, 32'd3);
    smp;
    tick;
    smp;
    tick;
    smp;
    rst = 1'b1; bus.req_valid_i = 1'b0;
    #1;
    check("ar_state", 64'(dut.state), 64'(S_IDLE));
    check("ar_stall", 64'(bus.stall_o), 64'd0);
    check("ar_valid", 64'(bus.result_valid_o), 64'd0);
    check("ar_start", 64'(bus.unit_start_o), 64'd0);
    check("ar_cancel", 64'(bus.unit_cancel_o), 64'd0);
    check("ar_result", 64'(bus.result_o), 64'd0);
    check("ar_opa", 64'(bus.unit_op_a_o), 64'd0);
    check("ar_opb", 64'(bus.unit_op_b_o), 64'd0);
    check("ar_a_uns", 64'(bus.unit_a_unsigned_o), 64'd1);
    check("ar_b_uns", 64'(bus.unit_b_unsigned_o), 64'd1);
    tick; rst = 1'b0;
    tick;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 clk  in  1  core clock; all state updates on the rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 req_valid_i  in  1  EX holds a M-extension instruction; held stable while stall_o=1.
REQ-004 op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-005 rs1_i, rs2_i  in  32 each  operands.
REQ-006 flush_i  in  1  pipeline flush (interrupt/branch); kills the in-flight operation.
REQ-007 stall_o  out  1  hold IF/ID/EX; result_o  out  32; result_valid_o  out  1.
REQ-008 unit_start_o  out  1  one-cycle start pulse to the iterative unit; unit_mul_or_div_o  out  1  (0 MUL, 1 DIV).
REQ-009 unit_op_a_o, unit_op_b_o  out  32 each; unit_a_unsigned_o, unit_b_unsigned_o  out  1 each; unit_cancel_o  out  1.
REQ-010 unit_result_i  in  64  MUL: product; DIV: {quotient, remainder}; unit_done_i  in  1  one-cycle pulse.

Function
REQ-011 FSM states IDLE, BUSY, DONE; the encoding is 2 bits.
REQ-012 In IDLE with req_valid_i=1 and flush_i=0: latch op, operands and signedness, then go to BUSY with unit_start_o=1 in the next cycle only.
REQ-013 Signedness: MUL/MULHU/DIVU/REMU set both operands unsigned; MULH/DIV/REM set both signed; MULHSU sets a signed, b unsigned.
REQ-014 Special division cases skip the unit and go IDLE->DONE directly, with no start pulse.
  - Divisor 0: quotient 32'hFFFF_FFFF, remainder rs1.
  - Signed 32'h8000_0000 / 32'hFFFF_FFFF: quotient 32'h8000_0000, remainder 0.
REQ-015 BUSY waits for unit_done_i, captures unit_result_i into an internal register, then goes to DONE.
REQ-016 DONE lasts exactly one cycle.
  - result_valid_o=1.
  - Next state is IDLE.
  - A new request presented in DONE is not accepted until IDLE.
REQ-017 Result selection:
  - MUL, REM, REMU take [31:0].
  - MULH, MULHSU, MULHU, DIV, DIVU take [63:32].
REQ-018 stall_o = req_valid_i & (state != DONE), which gives a minimum latency of 2 cycles for special cases and N+2 for a unit taking N cycles.
REQ-019 flush_i in BUSY: pulse unit_cancel_o for one cycle, go to IDLE, drop any later unit_done_i.
REQ-020 flush_i and unit_done_i in the same cycle: flush wins, no result_valid_o.
REQ-021 flush_i in DONE: result_valid_o is forced 0, go to IDLE.
REQ-022 unit_done_i in IDLE or DONE is ignored.
REQ-023 result_o holds its last value whenever result_valid_o=0.

Reset
REQ-024 On rst:
  - State is IDLE.
  - stall_o, result_valid_o, unit_start_o and unit_cancel_o are 0.
  - result_o, the operand outputs and the latched result are 32'h0.
  - The signedness outputs are 1 (unsigned).
  - The cache entry is invalid.
REQ-025 Reset during BUSY abandons the operation; the unit is reset by the same rst.

Configuration
REQ-026 Macro MULDIV_CACHE_EN.
  - When defined, the block keeps the last DIV-class operands, signedness and 64-bit result.
  - A DIV/REM (or DIVU/REMU) request matching the cached entry goes IDLE->DONE directly using the cached value.
  - Any flush or MUL-class operation invalidates the entry.
  - When undefined, no cache logic exists and every DIV-class operation uses the unit or the special path.

Structure
REQ-027 The op encodings, FSM state encodings, and MUL/DIV and Signed/Unsigned constants are defined in yadan_defs.v.
REQ-028 One sub-module, muldiv_special, is natural: purely combinational detection of divide-by-zero and overflow, plus the fixed result values.

Verification
REQ-029 MUL 7 x 6 with the unit done after 3 cycles -> one start pulse, result_o=42, result_valid_o in cycle 5, stall_o high for cycles 1-4.
REQ-030 DIV 32'h8000_0000 / 32'hFFFF_FFFF -> no start pulse, result_o=32'h8000_0000 in cycle 2; REMU 5 / 0 -> result_o=5.
REQ-031 MULHSU 32'hFFFF_FFFF x 2 -> signedness outputs a=0, b=1; unit result 64'hFFFF_FFFF_FFFF_FFFE -> result_o=32'hFFFF_FFFF.
REQ-032 flush_i in the 2nd BUSY cycle, then unit_done_i 2 cycles later -> unit_cancel_o pulse, no result_valid_o, state IDLE.
REQ-033 With MULDIV_CACHE_EN: DIV 100/7 then REM 100/7 -> REM completes in 2 cycles with result_o=2 and no start pulse; without the macro, a second start pulse is issued.
REQ-034 rst asserted mid-BUSY -> all outputs return to their reset values asynchronously.
